// File: rtl/vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen
//   Parametrised VGA timing and test-pattern generator. Produces HSYNC, VSYNC
//   and DE for any timing set, and an RGB565 pattern selected at runtime:
//   colour bars, grid, checkerboard or a solid colour.
//
// Ports
//   clk_pll      in   pixel clock, all logic on the rising edge
//   rst          in   synchronous reset, active-high
//   mode_i       in   2  pattern select: 0=bars 1=grid 2=checker 3=solid
//   mode_valid   in   capture mode_i/solid_color into the shadow register
//   solid_color  in   16 RGB565 colour used by the solid pattern
//   HSYNC        out  horizontal sync (active level HSYNC_POL)
//   VSYNC        out  vertical sync (active level VSYNC_POL)
//   DE           out  visible-area data enable
//   FRAME_START  out  one-cycle pulse together with pixel (0,0)
//   X, Y         out  PIXEL_GEN_BITS current column / line (valid when DE)
//   RED_OUT      out  5  red, GREEN_OUT out 6 green, BLUE_OUT out 5 blue
//
// Every output is registered from the current counter state, so all of them
// are aligned and lag the counters by exactly one clock.
// ---------------------------------------------------------------------------
module vga_pattern_gen #(
  parameter int   H_PIXELS          = 800,
  parameter int   H_FRONTPORCH      = 40,
  parameter int   H_SYNCTIME        = 128,
  parameter int   H_BACKPORCH       = 88,
  parameter int   V_LINES           = 600,
  parameter int   V_FRONTPORCH      = 1,
  parameter int   V_SYNCTIME        = 4,
  parameter int   V_BACKPORCH       = 23,
  parameter logic HSYNC_POL         = 1'b1,
  parameter logic VSYNC_POL         = 1'b1,
  parameter int   PIXEL_GEN_BITS    = 12,
  parameter int   NUMBER_OF_COLUMNS = 8,
  parameter int   GRID_STEP         = 32
) (
  input  logic                      clk_pll,
  input  logic                      rst,
  input  logic [1:0]                mode_i,
  input  logic                      mode_valid,
  input  logic [15:0]               solid_color,
  output logic                      HSYNC,
  output logic                      VSYNC,
  output logic                      DE,
  output logic                      FRAME_START,
  output logic [PIXEL_GEN_BITS-1:0] X,
  output logic [PIXEL_GEN_BITS-1:0] Y,
  output logic [4:0]                RED_OUT,
  output logic [5:0]                GREEN_OUT,
  output logic [4:0]                BLUE_OUT
);

  localparam int H_TOTAL = H_PIXELS + H_FRONTPORCH + H_SYNCTIME + H_BACKPORCH;
  localparam int V_TOTAL = V_LINES + V_FRONTPORCH + V_SYNCTIME + V_BACKPORCH;
  localparam int BAR_W   = H_PIXELS / NUMBER_OF_COLUMNS;

  localparam logic [PIXEL_GEN_BITS-1:0] H_LAST    = PIXEL_GEN_BITS'(H_TOTAL - 1);
  localparam logic [PIXEL_GEN_BITS-1:0] V_LAST    = PIXEL_GEN_BITS'(V_TOTAL - 1);
  localparam logic [PIXEL_GEN_BITS-1:0] H_VIS     = PIXEL_GEN_BITS'(H_PIXELS);
  localparam logic [PIXEL_GEN_BITS-1:0] V_VIS     = PIXEL_GEN_BITS'(V_LINES);
  localparam logic [PIXEL_GEN_BITS-1:0] HS_START  = PIXEL_GEN_BITS'(H_PIXELS + H_FRONTPORCH);
  localparam logic [PIXEL_GEN_BITS-1:0] HS_END    = PIXEL_GEN_BITS'(H_PIXELS + H_FRONTPORCH + H_SYNCTIME);
  localparam logic [PIXEL_GEN_BITS-1:0] VS_START  = PIXEL_GEN_BITS'(V_LINES + V_FRONTPORCH);
  localparam logic [PIXEL_GEN_BITS-1:0] VS_END    = PIXEL_GEN_BITS'(V_LINES + V_FRONTPORCH + V_SYNCTIME);
  localparam logic [PIXEL_GEN_BITS-1:0] BAR_LAST  = PIXEL_GEN_BITS'(BAR_W - 1);
  localparam logic [PIXEL_GEN_BITS-1:0] COL_LAST  = PIXEL_GEN_BITS'(NUMBER_OF_COLUMNS - 1);
  localparam logic [PIXEL_GEN_BITS-1:0] STEP_LAST = PIXEL_GEN_BITS'(GRID_STEP - 1);

  logic [PIXEL_GEN_BITS-1:0] h_cnt;
  logic [PIXEL_GEN_BITS-1:0] v_cnt;
  logic [PIXEL_GEN_BITS-1:0] grid_x;
  logic [PIXEL_GEN_BITS-1:0] grid_y;
  logic                      check_x;
  logic                      check_y;
  logic [PIXEL_GEN_BITS-1:0] bar_run;
  logic [PIXEL_GEN_BITS-1:0] bar_idx;
  logic [1:0]                shadow_mode;
  logic [15:0]               shadow_solid;
  logic [1:0]                active_mode;
  logic [15:0]               active_solid;
  logic [1:0]                eff_mode;
  logic [15:0]               eff_solid;
  logic                      h_last;
  logic                      v_last;
  logic                      frame_boundary;
  logic                      visible;
  logic                      hsync_act;
  logic                      vsync_act;
  logic [15:0]               pixel;
  logic [15:0]               rgb;

  assign h_last         = (h_cnt == H_LAST);
  assign v_last         = (v_cnt == V_LAST);
  assign frame_boundary = (h_cnt == '0) && (v_cnt == '0);
  assign visible        = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hsync_act      = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vsync_act      = (v_cnt >= VS_START) && (v_cnt < VS_END);

  // Fixed eight-entry colour-bar palette, indexed modulo 8.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  endfunction

  // Raster position: h_cnt sweeps the whole line, v_cnt advances on every
  // line wrap and wraps itself at the end of the frame.
  always_ff @(posedge clk_pll) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Divider-free pattern helpers that run in lock-step with h_cnt/v_cnt.
  // grid_x/grid_y hold the position modulo GRID_STEP and check_x/check_y the
  // parity of the square index. bar_run counts pixels inside the current bar;
  // the last bar never advances, so it absorbs the division remainder.
  always_ff @(posedge clk_pll) begin
    if (rst) begin
      grid_x  <= '0;
      grid_y  <= '0;
      check_x <= 1'b0;
      check_y <= 1'b0;
      bar_run <= '0;
      bar_idx <= '0;
    end else begin
      if (h_last) begin
        grid_x  <= '0;
        check_x <= 1'b0;
        bar_run <= '0;
        bar_idx <= '0;
        if (v_last) begin
          grid_y  <= '0;
          check_y <= 1'b0;
        end else if (grid_y == STEP_LAST) begin
          grid_y  <= '0;
          check_y <= ~check_y;
        end else begin
          grid_y <= grid_y + 1'b1;
        end
      end else begin
        if (grid_x == STEP_LAST) begin
          grid_x  <= '0;
          check_x <= ~check_x;
        end else begin
          grid_x <= grid_x + 1'b1;
        end
        if ((bar_run == BAR_LAST) && (bar_idx != COL_LAST)) begin
          bar_run <= '0;
          bar_idx <= bar_idx + 1'b1;
        end else begin
          bar_run <= bar_run + 1'b1;
        end
      end
    end
  end

  // Mode handshake: requests land in the shadow register at any time, and the
  // shadow is promoted to the active set only at pixel (0,0) so a frame is
  // never torn. A request in the boundary cycle itself only reaches the
  // shadow, so it waits for the next frame.
  always_ff @(posedge clk_pll) begin
    if (rst) begin
      shadow_mode  <= 2'd0;
      shadow_solid <= 16'h0000;
      active_mode  <= 2'd0;
      active_solid <= 16'h0000;
    end else begin
      if (mode_valid) begin
        shadow_mode  <= mode_i;
        shadow_solid <= solid_color;
      end
      if (frame_boundary) begin
        active_mode  <= shadow_mode;
        active_solid <= shadow_solid;
      end
    end
  end

  // Pixel (0,0) already belongs to the new frame, so at the boundary the
  // about-to-be-promoted shadow settings are used directly.
  assign eff_mode  = frame_boundary ? shadow_mode  : active_mode;
  assign eff_solid = frame_boundary ? shadow_solid : active_solid;

  // Pattern selection; blanking forces black.
  always_comb begin
    pixel = 16'h0000;
    case (eff_mode)
      2'd0:    pixel = bar_color(bar_idx[2:0]);
      2'd1:    pixel = ((grid_x == '0) || (grid_y == '0)) ? 16'hFFFF : 16'h0000;
      2'd2:    pixel = (check_x ^ check_y) ? 16'h0000 : 16'hFFFF;
      default: pixel = eff_solid;
    endcase
    if (!visible) begin
      pixel = 16'h0000;
    end
  end

  // Output register stage shared by every output so they stay aligned.
  always_ff @(posedge clk_pll) begin
    if (rst) begin
      HSYNC       <= ~HSYNC_POL;
      VSYNC       <= ~VSYNC_POL;
      DE          <= 1'b0;
      FRAME_START <= 1'b0;
      X           <= '0;
      Y           <= '0;
      rgb         <= 16'h0000;
    end else begin
      HSYNC       <= hsync_act ? HSYNC_POL : ~HSYNC_POL;
      VSYNC       <= vsync_act ? VSYNC_POL : ~VSYNC_POL;
      DE          <= visible;
      FRAME_START <= frame_boundary;
      X           <= h_cnt;
      Y           <= v_cnt;
      rgb         <= pixel;
    end
  end

  assign RED_OUT   = rgb[15:11];
  assign GREEN_OUT = rgb[10:5];
  assign BLUE_OUT  = rgb[4:0];

endmodule

// File: tb/tb_vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_pattern_gen
//   Self-checking bench for vga_pattern_gen on a shrunken timing set
//   (58 x 39 total, 40 x 30 visible) so whole frames run quickly. HSYNC
//   polarity is inverted and three bars are used so uneven bar widths
//   (13, 13, 14) and the idle-high HSYNC are exercised.
// ---------------------------------------------------------------------------
module tb_vga_pattern_gen;

  localparam int   HP    = 40;
  localparam int   HFP   = 4;
  localparam int   HSY   = 8;
  localparam int   HBP   = 6;
  localparam int   VL    = 30;
  localparam int   VFP   = 2;
  localparam int   VSY   = 3;
  localparam int   VBP   = 4;
  localparam logic HPOL  = 1'b0;
  localparam logic VPOL  = 1'b1;
  localparam int   NBITS = 12;
  localparam int   NC    = 3;
  localparam int   GS    = 4;
  localparam int   HT    = HP + HFP + HSY + HBP;
  localparam int   VT    = VL + VFP + VSY + VBP;
  localparam int   FRAME = HT * VT;
  localparam int   BW    = HP / NC;

  logic             clk_pll = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       mode_i = 2'd0;
  logic             mode_valid = 1'b0;
  logic [15:0]      solid_color = 16'h0000;
  logic             HSYNC, VSYNC, DE, FRAME_START;
  logic [NBITS-1:0] X, Y;
  logic [4:0]       RED_OUT;
  logic [5:0]       GREEN_OUT;
  logic [4:0]       BLUE_OUT;

  int vectors = 0;
  int errors  = 0;

  // Reference model state: next raster position and the two mode registers.
  int          np = 0;
  logic [1:0]  act_m = 2'd0, sh_m = 2'd0;
  logic [15:0] act_s = 16'h0, sh_s = 16'h0;
  logic [3:0]  exp_sig;
  logic [15:0] exp_rgb;
  logic [NBITS-1:0] exp_x, exp_y;
  int          exp_pos;

  vga_pattern_gen #(
    .H_PIXELS(HP), .H_FRONTPORCH(HFP), .H_SYNCTIME(HSY), .H_BACKPORCH(HBP),
    .V_LINES(VL), .V_FRONTPORCH(VFP), .V_SYNCTIME(VSY), .V_BACKPORCH(VBP),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .PIXEL_GEN_BITS(NBITS),
    .NUMBER_OF_COLUMNS(NC), .GRID_STEP(GS)
  ) dut (
    .clk_pll(clk_pll), .rst(rst), .mode_i(mode_i), .mode_valid(mode_valid),
    .solid_color(solid_color), .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE),
    .FRAME_START(FRAME_START), .X(X), .Y(Y), .RED_OUT(RED_OUT),
    .GREEN_OUT(GREEN_OUT), .BLUE_OUT(BLUE_OUT)
  );

  always #5 clk_pll = ~clk_pll;

  // Expected colour of a raster position straight from the pattern rules.
  function automatic logic [15:0] ref_color(input int h, input int v,
                                            input logic [1:0] m, input logic [15:0] s);
    int idx;
    if (!(h < HP && v < VL)) return 16'h0000;
    case (m)
      2'd0: begin
        idx = h / BW;
        if (idx > NC - 1) idx = NC - 1;
        case (idx % 8)
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      2'd1: return ((h % GS) == 0 || (v % GS) == 0) ? 16'hFFFF : 16'h0000;
      2'd2: return ((((h / GS) ^ (v / GS)) & 1) == 0) ? 16'hFFFF : 16'h0000;
      default: return s;
    endcase
  endfunction

  // Drive one clock of stimulus and advance the reference model to match.
  task automatic tick(input logic r, input logic mv, input logic [1:0] m,
                      input logic [15:0] sc);
    int h, v;
    rst = r; mode_valid = mv; mode_i = m; solid_color = sc;
    @(posedge clk_pll);
    if (r) begin
      np = 0; act_m = 2'd0; act_s = 16'h0; sh_m = 2'd0; sh_s = 16'h0;
      exp_sig = {~HPOL, ~VPOL, 1'b0, 1'b0};
      exp_rgb = 16'h0; exp_x = '0; exp_y = '0; exp_pos = -1;
    end else begin
      h = np % HT;
      v = np / HT;
      if (np == 0) begin
        act_m = sh_m;
        act_s = sh_s;
      end
      exp_sig = {(h >= HP + HFP && h < HP + HFP + HSY) ? HPOL : ~HPOL,
                 (v >= VL + VFP && v < VL + VFP + VSY) ? VPOL : ~VPOL,
                 (h < HP && v < VL), (np == 0)};
      exp_rgb = ref_color(h, v, act_m, act_s);
      exp_x   = NBITS'(h);
      exp_y   = NBITS'(v);
      exp_pos = np;
      if (mv) begin
        sh_m = m;
        sh_s = sc;
      end
      np = (np + 1) % FRAME;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom));
      vectors++;
      if ({HSYNC, VSYNC, DE, FRAME_START} !== exp_sig ||
          {RED_OUT, GREEN_OUT, BLUE_OUT} !== 16'h0000 || X !== '0 || Y !== '0) begin
        errors++;
        $display("[TB] FAIL reset_state: sig=%b rgb=%h x=%0d y=%0d, required sig=%b rgb=0000 x=0 y=0",
                 {HSYNC, VSYNC, DE, FRAME_START}, {RED_OUT, GREEN_OUT, BLUE_OUT}, X, Y, exp_sig);
      end
    end
  endtask

  task automatic test_timing_bars();
    int de_count = 0;
    int fs_first = -1;
    int fs_second = -1;
    for (int i = 0; i <= FRAME; i++) begin
      tick(1'b0, 1'b0, 2'($urandom), 16'($urandom));
      vectors++;
      if ({HSYNC, VSYNC, DE, FRAME_START} !== exp_sig ||
          {RED_OUT, GREEN_OUT, BLUE_OUT} !== exp_rgb ||
          (exp_sig[1] && (X !== exp_x || Y !== exp_y))) begin
        errors++;
        $display("[TB] FAIL timing_bars pos=%0d: sig=%b rgb=%h x=%0d y=%0d, required sig=%b rgb=%h x=%0d y=%0d",
                 exp_pos, {HSYNC, VSYNC, DE, FRAME_START}, {RED_OUT, GREEN_OUT, BLUE_OUT},
                 X, Y, exp_sig, exp_rgb, exp_x, exp_y);
      end
      if (i < FRAME && DE === 1'b1) de_count++;
      if (FRAME_START === 1'b1) begin
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) fs_second = i;
      end
    end
    vectors++;
    if (de_count != HP * VL) begin
      errors++;
      $display("[TB] FAIL de_count: got %0d, required %0d", de_count, HP * VL);
    end
    vectors++;
    if (fs_first != 0 || fs_second - fs_first != FRAME) begin
      errors++;
      $display("[TB] FAIL frame_period: first=%0d second=%0d, required 0 and %0d",
               fs_first, fs_second, FRAME);
    end
  endtask

  // Random mode requests mid-frame, including a decoy that a later request
  // overrides; each new setting must appear only from the next frame.
  task automatic test_modes();
    logic [1:0] order [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int k = 0; k < 4; k++) begin
      int req_at   = $urandom_range(HT, FRAME - 2);
      int decoy_at = $urandom_range(0, HT - 1);
      int n        = 0;
      int left     = -1;
      while (left != 0) begin
        logic mv = 1'b0;
        logic [1:0] m = 2'($urandom);
        if (n == decoy_at || n == req_at) mv = 1'b1;
        if (n == req_at) m = order[k];
        tick(1'b0, mv, m, 16'($urandom));
        n++;
        if (left > 0) left--;
        if (n > req_at && np == 0 && left < 0) left = FRAME;
        vectors++;
        if ({HSYNC, VSYNC, DE, FRAME_START} !== exp_sig ||
            {RED_OUT, GREEN_OUT, BLUE_OUT} !== exp_rgb ||
            (exp_sig[1] && (X !== exp_x || Y !== exp_y))) begin
          errors++;
          $display("[TB] FAIL modes m=%0d pos=%0d: sig=%b rgb=%h x=%0d y=%0d, required sig=%b rgb=%h x=%0d y=%0d",
                   act_m, exp_pos, {HSYNC, VSYNC, DE, FRAME_START}, {RED_OUT, GREEN_OUT, BLUE_OUT},
                   X, Y, exp_sig, exp_rgb, exp_x, exp_y);
        end
      end
    end
  endtask

  // Request solid red exactly in the boundary cycle: the frame it starts
  // must stay on the old pattern and only the following frame turns red.
  task automatic test_back_to_back();
    int guard = 0;
    while (np != 0 && guard < 2 * FRAME) begin
      tick(1'b0, 1'b0, 2'($urandom), 16'($urandom));
      guard++;
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick(1'b0, (i == 0), (i == 0) ? 2'd3 : 2'($urandom), (i == 0) ? 16'hF800 : 16'($urandom));
      vectors++;
      if ({HSYNC, VSYNC, DE, FRAME_START} !== exp_sig ||
          {RED_OUT, GREEN_OUT, BLUE_OUT} !== exp_rgb ||
          (exp_sig[1] && (X !== exp_x || Y !== exp_y))) begin
        errors++;
        $display("[TB] FAIL boundary_req i=%0d: sig=%b rgb=%h, required sig=%b rgb=%h",
                 i, {HSYNC, VSYNC, DE, FRAME_START}, {RED_OUT, GREEN_OUT, BLUE_OUT}, exp_sig, exp_rgb);
      end
    end
    vectors++;
    if (act_m !== 2'd3 || act_s !== 16'hF800) begin
      errors++;
      $display("[TB] FAIL boundary_model: reached mode %0d colour %h, required 3 F800", act_m, act_s);
    end
  endtask

  task automatic test_midframe_reset();
    int target = 20 * HT + 17;
    int guard = 0;
    while (np != target && guard < 2 * FRAME) begin
      tick(1'b0, 1'b0, 2'd0, 16'h0);
      guard++;
    end
    tick(1'b1, 1'b0, 2'd0, 16'h0);
    vectors++;
    if ({HSYNC, VSYNC, DE, FRAME_START} !== {~HPOL, ~VPOL, 2'b00} ||
        {RED_OUT, GREEN_OUT, BLUE_OUT} !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL midframe_reset: sig=%b rgb=%h, required sig=%b rgb=0000",
               {HSYNC, VSYNC, DE, FRAME_START}, {RED_OUT, GREEN_OUT, BLUE_OUT}, {~HPOL, ~VPOL, 2'b00});
    end
    tick(1'b0, 1'b0, 2'($urandom), 16'($urandom));
    vectors++;
    if (FRAME_START !== 1'b1 || DE !== 1'b1 || X !== '0 || Y !== '0 ||
        {RED_OUT, GREEN_OUT, BLUE_OUT} !== 16'hFFFF) begin
      errors++;
      $display("[TB] FAIL restart_origin: fs=%b de=%b x=%0d y=%0d rgb=%h, required fs=1 de=1 x=0 y=0 rgb=FFFF",
               FRAME_START, DE, X, Y, {RED_OUT, GREEN_OUT, BLUE_OUT});
    end
    for (int i = 0; i < 3 * HT; i++) begin
      tick(1'b0, 1'b0, 2'($urandom), 16'($urandom));
      vectors++;
      if ({HSYNC, VSYNC, DE, FRAME_START} !== exp_sig ||
          {RED_OUT, GREEN_OUT, BLUE_OUT} !== exp_rgb ||
          (exp_sig[1] && (X !== exp_x || Y !== exp_y))) begin
        errors++;
        $display("[TB] FAIL after_reset pos=%0d: sig=%b rgb=%h x=%0d, required sig=%b rgb=%h x=%0d",
                 exp_pos, {HSYNC, VSYNC, DE, FRAME_START}, {RED_OUT, GREEN_OUT, BLUE_OUT},
                 X, exp_sig, exp_rgb, exp_x);
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing_bars();
    test_modes();
    test_back_to_back();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
